// File: rtl/decode_pkg.sv
// Shared opcode constants, encodings and the decoded-entry record for decode_stage.
// DECODE_MULDIV_EN adds the md flag for M-extension OP instructions.
package decode_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;

  localparam logic [1:0] RW_NONE = 2'b00;
  localparam logic [1:0] RW_ALU  = 2'b01;
  localparam logic [1:0] RW_MEM  = 2'b10;
  localparam logic [1:0] RW_PC4  = 2'b11;

  localparam logic [1:0] BRA_NONE = 2'b00;
  localparam logic [1:0] BRA_JAL  = 2'b01;
  localparam logic [1:0] BRA_COND = 2'b10;
  localparam logic [1:0] BRA_ALU  = 2'b11;

  typedef enum logic [1:0] {
    SRC_NONE = RW_NONE,
    SRC_ALU  = RW_ALU,
    SRC_MEM  = RW_MEM,
    SRC_PC4  = RW_PC4
  } rw_src_t;

  typedef enum logic [1:0] {
    BR_NONE = BRA_NONE,
    BR_JAL  = BRA_JAL,
    BR_COND = BRA_COND,
    BR_ALU  = BRA_ALU
  } bra_mode_t;

  // State codes kept as explicit constants so existing encodings stay stable.
  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_HALT = 1'b1;

  typedef enum logic [0:0] {
    RUN  = ST_RUN,
    HALT = ST_HALT
  } state_t;

  typedef struct packed {
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    rw_src_t     rw_src;
    logic        alu_imm_b;
    logic        alu_pc_a;
    logic [2:0]  alu_op;
    logic        alu_alt;
    logic [31:0] imm;
    logic        cmp_z;
    logic        cmp_inv;
    bra_mode_t   bra_mode;
    logic        mem_en;
    logic        mem_we;
    logic [2:0]  mem_func;
    logic        illegal;
    logic        brk;
`ifdef DECODE_MULDIV_EN
    logic        md;
`endif
  } decoded_t;

  function automatic logic [31:0] sext12(input logic [11:0] v);
    return {{20{v[11]}}, v};
  endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Fetch-side and execute-side handshake/bus bundle of decode_stage.
// DECODE_MULDIV_EN adds the md signal.
interface decode_stage_if
  import decode_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) ();

  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_instr;
  logic [XLEN-1:0]   in_pc;

  logic              out_valid;
  logic              out_ready;
  logic [XLEN-1:0]   out_pc;
  logic [REG_AW-1:0] rs1;
  logic [REG_AW-1:0] rs2;
  logic [REG_AW-1:0] rd;
  rw_src_t           rw_src;
  logic              alu_imm_b;
  logic              alu_pc_a;
  logic [2:0]        alu_op;
  logic              alu_alt;
  logic [XLEN-1:0]   imm;
  logic              cmp_z;
  logic              cmp_inv;
  bra_mode_t         bra_mode;
  logic              mem_en;
  logic              mem_we;
  logic [2:0]        mem_func;
  logic              illegal;
  logic              brk;
`ifdef DECODE_MULDIV_EN
  logic              md;
`endif

  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
`ifdef DECODE_MULDIV_EN
    output md,
`endif
    output in_ready, out_valid, out_pc, rs1, rs2, rd, rw_src, alu_imm_b, alu_pc_a,
           alu_op, alu_alt, imm, cmp_z, cmp_inv, bra_mode, mem_en, mem_we, mem_func,
           illegal, brk
  );

  modport master (
    output in_valid, in_instr, in_pc, out_ready,
`ifdef DECODE_MULDIV_EN
    input  md,
`endif
    input  in_ready, out_valid, out_pc, rs1, rs2, rd, rw_src, alu_imm_b, alu_pc_a,
           alu_op, alu_alt, imm, cmp_z, cmp_inv, bra_mode, mem_en, mem_we, mem_func,
           illegal, brk
  );

endinterface

// File: rtl/decode_comb.sv
// Pure combinational RV32I instruction -> decoded_t translation.
// DECODE_MULDIV_EN makes OP with funct7=0000001 legal and sets md.
module decode_comb
  import decode_pkg::*;
(
  input  logic [31:0] instr,
  output decoded_t    dec
);

  logic [6:0]  opcode;
  logic [6:0]  funct7;
  logic [2:0]  funct3;
  logic [4:0]  rs1_f;
  logic [4:0]  rs2_f;
  logic [4:0]  rd_f;
  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_b;
  logic [31:0] imm_u;
  logic [31:0] imm_j;
  logic        legal;

  assign opcode = instr[6:0];
  assign rd_f   = instr[11:7];
  assign funct3 = instr[14:12];
  assign rs1_f  = instr[19:15];
  assign rs2_f  = instr[24:20];
  assign funct7 = instr[31:25];

  assign imm_i = sext12(instr[31:20]);
  assign imm_s = sext12({instr[31:25], instr[11:7]});
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'b0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  always_comb begin
    dec   = '0;
    legal = 1'b1;
    case (opcode)
      OPC_LUI: begin
        dec.rd        = rd_f;
        dec.rw_src    = SRC_ALU;
        dec.alu_imm_b = 1'b1;
        dec.imm       = imm_u;
      end
      OPC_AUIPC: begin
        dec.rd        = rd_f;
        dec.rw_src    = SRC_ALU;
        dec.alu_imm_b = 1'b1;
        dec.alu_pc_a  = 1'b1;
        dec.imm       = imm_u;
      end
      OPC_JAL: begin
        dec.rd       = rd_f;
        dec.rw_src   = SRC_PC4;
        dec.bra_mode = BR_JAL;
        dec.imm      = imm_j;
      end
      OPC_JALR: begin
        legal         = (funct3 == 3'b000);
        dec.rs1       = rs1_f;
        dec.rd        = rd_f;
        dec.rw_src    = SRC_PC4;
        dec.alu_imm_b = 1'b1;
        dec.bra_mode  = BR_ALU;
        dec.imm       = imm_i;
      end
      OPC_BRANCH: begin
        legal        = (funct3[2:1] != 2'b01);
        dec.rs1      = rs1_f;
        dec.rs2      = rs2_f;
        dec.bra_mode = BR_COND;
        dec.cmp_z    = ~funct3[2];
        dec.cmp_inv  = funct3[0];
        dec.imm      = imm_b;
      end
      OPC_LOAD: begin
        legal         = !((funct3 == 3'b011) || (funct3[2:1] == 2'b11));
        dec.rs1       = rs1_f;
        dec.rd        = rd_f;
        dec.rw_src    = SRC_MEM;
        dec.alu_imm_b = 1'b1;
        dec.mem_en    = 1'b1;
        dec.mem_func  = funct3;
        dec.imm       = imm_i;
      end
      OPC_STORE: begin
        legal         = (funct3 <= 3'b010);
        dec.rs1       = rs1_f;
        dec.rs2       = rs2_f;
        dec.alu_imm_b = 1'b1;
        dec.mem_en    = 1'b1;
        dec.mem_we    = 1'b1;
        dec.mem_func  = funct3;
        dec.imm       = imm_s;
      end
      OPC_OP_IMM: begin
        dec.rs1       = rs1_f;
        dec.rd        = rd_f;
        dec.rw_src    = SRC_ALU;
        dec.alu_imm_b = 1'b1;
        dec.alu_op    = funct3;
        dec.imm       = imm_i;
        if (funct3 == 3'b001) begin
          legal = (funct7 == F7_BASE);
        end else if (funct3 == 3'b101) begin
          legal       = (funct7 == F7_BASE) || (funct7 == F7_ALT);
          dec.alu_alt = instr[30];
        end
      end
      OPC_OP: begin
        dec.rs1     = rs1_f;
        dec.rs2     = rs2_f;
        dec.rd      = rd_f;
        dec.rw_src  = SRC_ALU;
        dec.alu_op  = funct3;
        dec.alu_alt = instr[30];
        if (funct7 == F7_ALT) begin
          legal = (funct3 == 3'b000) || (funct3 == 3'b101);
`ifdef DECODE_MULDIV_EN
        end else if (funct7 == F7_MULDIV) begin
          dec.md      = 1'b1;
          dec.alu_alt = 1'b0;
`endif
        end else begin
          legal = (funct7 == F7_BASE);
        end
      end
      OPC_SYSTEM: begin
        legal   = (instr == INSTR_EBREAK);
        dec.brk = 1'b1;
      end
      default: legal = 1'b0;
    endcase

    // Illegal entries carry no side effects at all; x0 destinations never write back.
    if (!legal) begin
      dec         = '0;
      dec.illegal = 1'b1;
    end else if (dec.rd == '0) begin
      dec.rw_src = SRC_NONE;
    end
  end

endmodule

// File: rtl/decode_stage.sv
// Registered RV32I decode stage: valid/ready in and out, EBREAK halt/resume, flush.
// DECODE_MULDIV_EN enables M-extension decode and the md output.
module decode_stage
  import decode_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int REG_AW       = 5,
  parameter bit RESET_HALTED = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  decode_stage_if.slave io,
  output logic          halted,
  input  logic          resume,
  input  logic          flush
);

  localparam state_t RESET_STATE = RESET_HALTED ? HALT : RUN;

  decoded_t        dec;
  decoded_t        held;
  logic [XLEN-1:0] pc_q;
  logic            out_valid_q;
  logic            in_ready;
  logic            accept;
  state_t          state;

  decode_comb u_comb (
    .instr (io.in_instr),
    .dec   (dec)
  );

  assign in_ready = (state == RUN) && !flush && (!out_valid_q || io.out_ready);
  assign accept   = io.in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RESET_STATE;
      out_valid_q <= 1'b0;
      held        <= '0;
      pc_q        <= '0;
    end else begin
      if (flush) begin
        out_valid_q <= 1'b0;
      end else if (accept) begin
        out_valid_q <= 1'b1;
        held        <= dec;
        pc_q        <= io.in_pc;
      end else if (io.out_ready) begin
        out_valid_q <= 1'b0;
      end

      // The EBREAK entry itself is still loaded above; only later accepts stop.
      if (state == RUN) begin
        if (accept && dec.brk) state <= HALT;
      end else if (resume) begin
        state <= RUN;
      end
    end
  end

  assign halted       = (state == HALT);
  assign io.in_ready  = in_ready;
  assign io.out_valid = out_valid_q;
  assign io.out_pc    = pc_q;
  assign io.rs1       = REG_AW'(held.rs1);
  assign io.rs2       = REG_AW'(held.rs2);
  assign io.rd        = REG_AW'(held.rd);
  assign io.rw_src    = held.rw_src;
  assign io.alu_imm_b = held.alu_imm_b;
  assign io.alu_pc_a  = held.alu_pc_a;
  assign io.alu_op    = held.alu_op;
  assign io.alu_alt   = held.alu_alt;
  assign io.imm       = XLEN'($signed(held.imm));
  assign io.cmp_z     = held.cmp_z;
  assign io.cmp_inv   = held.cmp_inv;
  assign io.bra_mode  = held.bra_mode;
  assign io.mem_en    = held.mem_en;
  assign io.mem_we    = held.mem_we;
  assign io.mem_func  = held.mem_func;
  assign io.illegal   = held.illegal;
  assign io.brk       = held.brk;
`ifdef DECODE_MULDIV_EN
  assign io.md        = held.md;
`endif

endmodule
